// File: rtl/change_event_queue_pkg.sv
// Shared types for the change-event queue: FIFO entry layout and detector FSM states.
package change_event_queue_pkg;

    localparam int unsigned DATA_W      = 8;
    // Widest delta a queue entry can carry; TS_WIDTH of the top must not exceed it.
    localparam int unsigned DELTA_MAX_W = 16;

    typedef logic [DATA_W-1:0]      ceq_data_t;
    typedef logic [DELTA_MAX_W-1:0] ceq_delta_t;

    typedef struct packed {
        ceq_data_t  data;
        ceq_delta_t delta;
    } ceq_entry_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } ceq_state_t;

endpackage

// File: rtl/change_event_queue_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted only
// when a pop happens on the same edge, otherwise it is silently ignored.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];

    // Pop is evaluated first so a full FIFO can take a write in the slot being freed.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/change_event_queue.sv
// Detects changes on an 8-bit sample stream and queues {new value, cycles since
// the previous change} for a ready/valid consumer.
module change_event_queue
    import change_event_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TS_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [7:0]               XIN,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [7:0]               OUT_DATA,
    output logic [TS_WIDTH-1:0]      OUT_DELTA,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERFLOW
);

    localparam logic [TS_WIDTH-1:0] DELTA_SAT     = '1;
    localparam ceq_delta_t          DELTA_SAT_EXT = ceq_delta_t'(DELTA_SAT);

    ceq_state_t          r_state;
    ceq_state_t          w_state_next;
    logic [7:0]          r_prev;
    logic [TS_WIDTH-1:0] r_delta;
    logic                r_overflow;

    logic                w_event;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    ceq_entry_t          w_push_entry;
    ceq_entry_t          w_head;

    always_comb begin
        w_state_next = r_state;
        w_event      = 1'b0;
        case (r_state)
            INIT: w_state_next = RUN;
            RUN:  w_event      = (XIN != r_prev);
            default: w_state_next = INIT;
        endcase
    end

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.data  = XIN;
        w_push_entry.delta = ceq_delta_t'(r_delta);
    end

    assign w_pop = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= INIT;
            r_prev     <= '0;
            r_delta    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_prev  <= XIN;
            // Dropped events restart the count just like accepted ones.
            if (r_state == INIT || w_event) begin
                r_delta <= TS_WIDTH'(1);
            end else if (r_delta != DELTA_SAT) begin
                r_delta <= r_delta + 1'b1;
            end
            if (w_event && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ceq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_push  (w_event),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (LEVEL)
    );

    assign OUT_VALID = !w_empty;
    assign OUT_DATA  = w_head.data;
    assign OUT_DELTA = (w_head.delta > DELTA_SAT_EXT) ? DELTA_SAT : w_head.delta[TS_WIDTH-1:0];
    assign OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_change_event_queue.sv
// Randomised and directed bench for change_event_queue against a queue-based model.
module tb_change_event_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TSW   = 8;
    localparam int unsigned SAT   = 255;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [7:0]     XIN;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [7:0]     OUT_DATA;
    logic [TSW-1:0] OUT_DELTA;
    logic [2:0]     LEVEL;
    logic           OVERFLOW;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        logic [7:0]  d;
        int unsigned dl;
    } ent_t;

    ent_t        q[$];
    bit          m_run  = 1'b0;
    bit          m_ovf  = 1'b0;
    logic [7:0]  m_prev = 8'h00;
    int unsigned m_last = 0;
    int unsigned cyc    = 0;

    change_event_queue #(
        .DEPTH    (DEPTH),
        .TS_WIDTH (TSW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .XIN       (XIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_DELTA (OUT_DELTA),
        .LEVEL     (LEVEL),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Model of one clock edge: delta is the edge distance to the last event.
    task automatic model_edge(input logic [7:0] x, input logic rdy, input logic rst);
        bit          pop;
        int unsigned d;
        ent_t        e;
        if (rst) begin
            q.delete();
            m_run  = 1'b0;
            m_ovf  = 1'b0;
            m_prev = 8'h00;
        end else begin
            pop = (q.size() > 0) && rdy;
            if (pop) void'(q.pop_front());
            if (!m_run) begin
                m_run  = 1'b1;
                m_last = cyc;
            end else if (x != m_prev) begin
                d = cyc - m_last;
                if (d > SAT) d = SAT;
                e.d  = x;
                e.dl = d;
                if (q.size() < DEPTH) q.push_back(e);
                else m_ovf = 1'b1;
                m_last = cyc;
            end
            m_prev = x;
        end
        cyc++;
    endtask

    task automatic tick(input logic [7:0] x, input logic rdy, input logic rst);
        XIN       = x;
        OUT_READY = rdy;
        RESET     = rst;
        model_edge(x, rdy, rst);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        tick(8'hA5, 1'b1, 1'b1);
        tick(8'h3C, 1'b0, 1'b1);
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0", OUT_VALID);
        end
        n_checks++;
        if (LEVEL !== 3'd0) begin
            n_errors++; $display("FAIL reset_level: got %0d want 0", LEVEL);
        end
        n_checks++;
        if (OVERFLOW !== 1'b0) begin
            n_errors++; $display("FAIL reset_overflow: got %b want 0", OVERFLOW);
        end
    endtask

    task automatic test_idle();
        tick(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(8'h00, 1'b0, 1'b0);
            n_checks++;
            if (OUT_VALID !== 1'b0 || LEVEL !== 3'd0) begin
                n_errors++;
                $display("FAIL idle_cycle%0d: valid=%b level=%0d want valid=0 level=0", i, OUT_VALID, LEVEL);
            end
        end
        n_checks++;
        if (OVERFLOW !== 1'b0) begin
            n_errors++; $display("FAIL idle_overflow: got %b want 0", OVERFLOW);
        end
    endtask

    task automatic test_single_event();
        tick(8'h00, 1'b1, 1'b1);
        tick(8'h00, 1'b1, 1'b0);
        tick(8'h00, 1'b1, 1'b0);
        tick(8'h00, 1'b1, 1'b0);
        n_checks++;
        if (OUT_VALID !== 1'b0) begin
            n_errors++; $display("FAIL single_pre_valid: got %b want 0", OUT_VALID);
        end
        tick(8'h5A, 1'b1, 1'b0);
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h5A || OUT_DELTA !== 8'd3) begin
            n_errors++;
            $display("FAIL single_entry: valid=%b data=%h delta=%0d want valid=1 data=5a delta=3", OUT_VALID, OUT_DATA, OUT_DELTA);
        end
        tick(8'h5A, 1'b1, 1'b0);
        n_checks++;
        if (OUT_VALID !== 1'b0 || LEVEL !== 3'd0) begin
            n_errors++; $display("FAIL single_popped: valid=%b level=%0d want 0 0", OUT_VALID, LEVEL);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_d [4] = '{8'h02, 8'h01, 8'h02, 8'h01};
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick((i % 2 == 0) ? 8'h02 : 8'h01, 1'b0, 1'b0);
        n_checks++;
        if (LEVEL !== 3'd4 || OVERFLOW !== 1'b1) begin
            n_errors++; $display("FAIL ovf_full: level=%0d ovf=%b want 4 1", LEVEL, OVERFLOW);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_d[i] || OUT_DELTA !== 8'd1) begin
                n_errors++;
                $display("FAIL ovf_drain%0d: valid=%b data=%h delta=%0d want 1 %h 1", i, OUT_VALID, OUT_DATA, OUT_DELTA, exp_d[i]);
            end
            tick(8'h01, 1'b1, 1'b0);
        end
        n_checks++;
        if (OUT_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            n_errors++; $display("FAIL ovf_after_drain: valid=%b ovf=%b want 0 1", OUT_VALID, OVERFLOW);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_d [4] = '{8'h01, 8'h02, 8'h01, 8'h77};
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick((i % 2 == 0) ? 8'h02 : 8'h01, 1'b0, 1'b0);
        tick(8'h77, 1'b1, 1'b0);
        n_checks++;
        if (LEVEL !== 3'd4 || OVERFLOW !== 1'b0) begin
            n_errors++; $display("FAIL fpp_level: level=%0d ovf=%b want 4 0", LEVEL, OVERFLOW);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== exp_d[i] || OUT_DELTA !== 8'd1) begin
                n_errors++;
                $display("FAIL fpp_drain%0d: valid=%b data=%h delta=%0d want 1 %h 1", i, OUT_VALID, OUT_DATA, OUT_DELTA, exp_d[i]);
            end
            tick(8'h77, 1'b1, 1'b0);
        end
    endtask

    task automatic test_saturation();
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) tick(8'h33, 1'b1, 1'b0);
        tick(8'h34, 1'b1, 1'b0);
        n_checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h34 || OUT_DELTA !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_delta: valid=%b data=%h delta=%0d want 1 34 255", OUT_VALID, OUT_DATA, OUT_DELTA);
        end
        tick(8'h34, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h01, 1'b0, 1'b0);
        tick(8'h02, 1'b0, 1'b0);
        tick(8'h03, 1'b0, 1'b0);
        n_checks++;
        if (LEVEL !== 3'd3) begin
            n_errors++; $display("FAIL mid_prefill: level=%0d want 3", LEVEL);
        end
        tick(8'h99, 1'b0, 1'b1);
        n_checks++;
        if (LEVEL !== 3'd0 || OUT_VALID !== 1'b0 || OVERFLOW !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset: level=%0d valid=%b ovf=%b want 0 0 0", LEVEL, OUT_VALID, OVERFLOW);
        end
        tick(8'h55, 1'b0, 1'b0);
        n_checks++;
        if (LEVEL !== 3'd0 || OUT_VALID !== 1'b0) begin
            n_errors++; $display("FAIL mid_first_edge: level=%0d valid=%b want 0 0", LEVEL, OUT_VALID);
        end
        tick(8'h55, 1'b0, 1'b0);
        tick(8'h56, 1'b0, 1'b0);
        n_checks++;
        if (LEVEL !== 3'd1 || OUT_DATA !== 8'h56 || OUT_DELTA !== 8'd2) begin
            n_errors++; $display("FAIL mid_restart: level=%0d data=%h delta=%0d want 1 56 2", LEVEL, OUT_DATA, OUT_DELTA);
        end
    endtask

    task automatic test_random();
        logic [7:0] x;
        logic       rdy;
        logic       rst;
        bit         ev;
        x = 8'h00;
        tick(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 35) x = 8'($urandom_range(0, 3));
            if ((i / 500) % 2 == 1 && $urandom_range(0, 9) != 0) x = m_prev;
            rdy = ($urandom_range(0, 99) < 45);
            rst = ($urandom_range(0, 599) == 0);
            tick(x, rdy, rst);
            ev = (q.size() > 0);
            n_checks++;
            if (OUT_VALID !== ev || LEVEL !== 3'(q.size()) || OVERFLOW !== m_ovf) begin
                n_errors++;
                $display("FAIL rand_status@%0d: valid=%b level=%0d ovf=%b want %b %0d %b", i, OUT_VALID, LEVEL, OVERFLOW, ev, q.size(), m_ovf);
            end
            if (ev) begin
                n_checks++;
                if (OUT_DATA !== q[0].d || OUT_DELTA !== 8'(q[0].dl)) begin
                    n_errors++;
                    $display("FAIL rand_head@%0d: data=%h delta=%0d want %h %0d", i, OUT_DATA, OUT_DELTA, q[0].d, q[0].dl);
                end
            end
        end
    endtask

    initial begin
        RESET     = 1'b1;
        XIN       = 8'h00;
        OUT_READY = 1'b0;
        test_reset();
        test_idle();
        test_single_event();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
